// File: rtl/bootloader_controller.sv
// bootloader_controller
//   Serial program loader for the 4-bit CPU. While bl_programm_i is high the
//   core is halted and each 8N1 UART byte received on rx_i is written as one
//   program word (low WORD_WIDTH bits of the byte) into program memory,
//   starting at address 0. Leaving programming mode releases the core through
//   a one-cycle cpu_reset_o pulse.
//
//   Ports
//     clk_i          clock, rising edge
//     reset_ni       asynchronous active-low reset
//     bl_programm_i  programming-mode request (synchronous, level)
//     rx_i           UART receive line, idle high, asynchronous
//     mem_we_o       one-cycle memory write strobe
//     mem_addr_o     write address (held outside write cycles)
//     mem_data_o     write data (held outside write cycles)
//     cpu_halt_o     core stall while high
//     cpu_reset_o    one-cycle core reset on leaving programming mode
//     load_done_o    all MEMORY_REGISTERS words written
//     frame_err_o    sticky: a byte arrived with stop bit = 0
module bootloader_controller #(
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int MEMORY_REGISTERS     = 16,
    parameter int WORD_WIDTH           = 7,
    parameter int CLKS_PER_BIT         = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            bl_programm_i,
    input  logic                            rx_i,
    output logic                            mem_we_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [WORD_WIDTH-1:0]           mem_data_o,
    output logic                            cpu_halt_o,
    output logic                            cpu_reset_o,
    output logic                            load_done_o,
    output logic                            frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [MEMORY_ADDRESS_WIDTH-1:0] ADDR_LAST =
        MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);

    typedef enum logic [2:0] {
        S_OFF, S_IDLE, S_START, S_DATA, S_STOP, S_RECOVER, S_WRITE, S_DONE
    } state_t;

    state_t                          state;
    logic                            rx_meta, rx_sync;
    logic [CNT_W-1:0]                clk_cnt;
    logic [2:0]                      bit_cnt;
    logic [WORD_WIDTH-1:0]           data_reg;
    logic [MEMORY_ADDRESS_WIDTH-1:0] addr;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= S_OFF;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            data_reg    <= '0;
            addr        <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            cpu_halt_o  <= 1'b0;
            cpu_reset_o <= 1'b0;
            load_done_o <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            mem_we_o    <= 1'b0;
            cpu_reset_o <= 1'b0;
            if (state != S_OFF && !bl_programm_i) begin
                // Exit from any active state; an in-flight byte is dropped.
                state       <= S_OFF;
                cpu_halt_o  <= 1'b0;
                cpu_reset_o <= 1'b1;
            end else begin
                case (state)
                    S_OFF: begin
                        cpu_halt_o <= 1'b0;
                        if (bl_programm_i) begin
                            state       <= S_IDLE;
                            addr        <= '0;
                            load_done_o <= 1'b0;
                            frame_err_o <= 1'b0;
                            cpu_halt_o  <= 1'b1;
                        end
                    end
                    S_IDLE: begin
                        if (!rx_sync) begin
                            state   <= S_START;
                            clk_cnt <= '0;
                            bit_cnt <= '0;
                        end
                    end
                    S_START: begin
                        if (clk_cnt == HALF_LAST) begin
                            clk_cnt <= '0;
                            state   <= rx_sync ? S_IDLE : S_DATA;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (clk_cnt == BIT_LAST) begin
                            clk_cnt <= '0;
                            // Only the bits that reach memory are kept.
                            if (int'(bit_cnt) < WORD_WIDTH)
                                data_reg[bit_cnt] <= rx_sync;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7)
                                state <= S_STOP;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (clk_cnt == BIT_LAST) begin
                            clk_cnt <= '0;
                            if (rx_sync) begin
                                // Strobe and bus are registered on entry so
                                // they are valid throughout the WRITE cycle.
                                state      <= S_WRITE;
                                mem_we_o   <= 1'b1;
                                mem_addr_o <= addr;
                                mem_data_o <= data_reg;
                            end else begin
                                state       <= S_RECOVER;
                                frame_err_o <= 1'b1;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    S_RECOVER: begin
                        if (rx_sync)
                            state <= S_IDLE;
                    end
                    S_WRITE: begin
                        addr <= addr + 1'b1;
                        if (addr == ADDR_LAST) begin
                            state       <= S_DONE;
                            load_done_o <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_DONE: begin
                        load_done_o <= 1'b1;
                    end
                    default: state <= S_OFF;
                endcase
            end
        end
    end

endmodule
